rv32i_id_ex_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 52 +++++
 rtl/rv32i_fwd_mux.sv | 54 +++++
 rtl/rv32i_id_ex_stage.sv | 171 +++++++++++++++++
 tb/tb_rv32i_id_ex_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Purpose : shared constants and types for the RV32I ID/EX operand-select slice.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: datapath width, base opcodes, forwarding-source enum, the ID/EX
// pipeline record and a small RAW-match helper shared by the stage and mux.
package rv32i_pkg;

   // Only a 32-bit datapath is supported.
   localparam int XLEN = 32;

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [1:0] {
      FWD_RF,
      FWD_MEM,
      FWD_WB
   } fwd_sel_t;

   // Everything the EX slot keeps between edges.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic            a_pc;
      logic            b_imm;
      logic            reg_write;
      logic            is_load;
   } idex_t;

   // True when a writer (wr_en, rd) produces the register rs reads.
   // x0 is hard-wired to zero, so a write to it never counts as a producer.
   function automatic logic rs_hit(input logic       wr_en,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs);
      return wr_en && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/rv32i_fwd_mux.sv
// Purpose : picks the freshest value of one source register (MEM > WB > captured).
// Latency : purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
//
// Ports:
//   rs / rf_data                      - register index and value captured at ID
//   mem_rd / mem_reg_write / mem_result - MEM-stage producer
//   wb_rd  / wb_reg_write  / wb_result  - WB-stage producer
//   fwd_data                          - operand value to use in EX
// Build option: RV32I_FWD_EN enables the bypass; without it the captured
// value passes straight through and the stage stalls instead.
module rv32i_fwd_mux
   import rv32i_pkg::*;
(
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic [4:0]      mem_rd,
   input  logic            mem_reg_write,
   input  logic [XLEN-1:0] mem_result,
   input  logic [4:0]      wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic [XLEN-1:0] fwd_data
);

`ifdef RV32I_FWD_EN
   fwd_sel_t sel;

   // MEM is younger than WB, so it wins when both write the same register.
   always_comb begin
      sel = FWD_RF;
      if (rs_hit(mem_reg_write, mem_rd, rs)) begin
         sel = FWD_MEM;
      end else if (rs_hit(wb_reg_write, wb_rd, rs)) begin
         sel = FWD_WB;
      end
   end

   always_comb begin
      case (sel)
         FWD_MEM: fwd_data = mem_result;
         FWD_WB:  fwd_data = wb_result;
         default: fwd_data = rf_data;
      endcase
   end
`else
   // No bypass in this build: hazards are resolved by stalling upstream.
   logic unused_fwd_inputs;
   assign unused_fwd_inputs = ^{rs, mem_rd, mem_reg_write, mem_result,
                                wb_rd, wb_reg_write, wb_result};
   assign fwd_data = rf_data;
`endif

endmodule

// File: rtl/rv32i_id_ex_stage.sv
// Purpose : ID/EX pipeline register with RAW hazard handling; drives ALU operands.
// Latency : an instruction presented on id_* appears on ex_* one cycle later.
// Backpressure: ex_stall holds the slot; hazard_stall asks IF/ID to hold for one bubble.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   id_*              - decoded instruction and register-file read data
//   ex_stall, flush   - downstream hold and branch/jump kill of the EX slot
//   mem_*, wb_*       - later-stage producers for forwarding / refresh / hazard checks
//   hazard_stall      - combinational request to hold IF/ID this cycle
//   ex_*              - registered instruction fields and final ALU operands
// Build option: RV32I_FWD_EN selects MEM/WB forwarding; when undefined,
// operands come from captured data only and any EX/MEM RAW stalls.
module rv32i_id_ex_stage
   import rv32i_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [6:0]      id_opcode,
   input  logic [2:0]      id_funct3,
   input  logic [6:0]      id_funct7,
   input  logic            id_a_pc,
   input  logic            id_b_imm,
   input  logic            id_reg_write,
   input  logic            id_is_load,
   input  logic            ex_stall,
   input  logic            flush,
   input  logic [4:0]      mem_rd,
   input  logic            mem_reg_write,
   input  logic [XLEN-1:0] mem_result,
   input  logic [4:0]      wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic            hazard_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [XLEN-1:0] ex_store_data,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic [6:0]      ex_funct7,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_is_load
);

   idex_t           ex_q;
   idex_t           ex_d;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;
   logic            ex_rd_match;

   // ---------------------------------------------------------------
   // Hazard detection against the instruction currently in decode.
   // Deliberately not gated by flush: upstream discards it then.
   // ---------------------------------------------------------------
   assign ex_rd_match = (ex_q.rd != 5'd0) &&
                        ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

`ifdef RV32I_FWD_EN
   // Only a load cannot be bypassed: its data exists one stage too late.
   assign hazard_stall = id_valid & ex_q.valid & ex_q.is_load & ex_rd_match;
`else
   // Without bypass, any pending EX or MEM write to a source must drain first.
   logic mem_rd_match;
   assign mem_rd_match = rs_hit(mem_reg_write, mem_rd, id_rs1) |
                         rs_hit(mem_reg_write, mem_rd, id_rs2);
   assign hazard_stall = id_valid &
                         ((ex_q.valid & ex_q.reg_write & ex_rd_match) | mem_rd_match);
`endif

   // ---------------------------------------------------------------
   // Next-state: flush > hold > bubble > capture.
   // ---------------------------------------------------------------
   always_comb begin
      ex_d = ex_q;
      if (flush) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
      end else if (ex_stall) begin
         // A producer may retire through WB while we are held; pick up its
         // result now, because nobody will forward it once it is gone.
         if (rs_hit(wb_reg_write, wb_rd, ex_q.rs1)) begin
            ex_d.rs1_data = wb_result;
         end
         if (rs_hit(wb_reg_write, wb_rd, ex_q.rs2)) begin
            ex_d.rs2_data = wb_result;
         end
      end else if (hazard_stall) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
      end else begin
         ex_d.valid     = id_valid;
         ex_d.pc        = id_pc;
         ex_d.rs1       = id_rs1;
         ex_d.rs2       = id_rs2;
         ex_d.rd        = id_rd;
         ex_d.rs1_data  = id_rs1_data;
         ex_d.rs2_data  = id_rs2_data;
         ex_d.imm       = id_imm;
         ex_d.opcode    = id_opcode;
         ex_d.funct3    = id_funct3;
         ex_d.funct7    = id_funct7;
         ex_d.a_pc      = id_a_pc;
         ex_d.b_imm     = id_b_imm;
         // An empty slot must never claim a register write.
         ex_d.reg_write = id_valid & id_reg_write;
         ex_d.is_load   = id_is_load;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= '0;
      end else begin
         ex_q <= ex_d;
      end
   end

   // ---------------------------------------------------------------
   // Operand selection. In the non-forwarding build these muxes reduce
   // to wires on the captured data.
   // ---------------------------------------------------------------
   rv32i_fwd_mux u_fwd_rs1 (
      .rs            (ex_q.rs1),
      .rf_data       (ex_q.rs1_data),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .fwd_data      (fwd_rs1)
   );

   rv32i_fwd_mux u_fwd_rs2 (
      .rs            (ex_q.rs2),
      .rf_data       (ex_q.rs2_data),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_result    (mem_result),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_result     (wb_result),
      .fwd_data      (fwd_rs2)
   );

   assign ex_a          = ex_q.a_pc  ? ex_q.pc  : fwd_rs1;
   assign ex_b          = ex_q.b_imm ? ex_q.imm : fwd_rs2;
   // Stores need the real rs2 even though b carries the address offset.
   assign ex_store_data = fwd_rs2;

   assign ex_valid     = ex_q.valid;
   assign ex_pc        = ex_q.pc;
   assign ex_opcode    = ex_q.opcode;
   assign ex_funct3    = ex_q.funct3;
   assign ex_funct7    = ex_q.funct7;
   assign ex_rd        = ex_q.rd;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_is_load   = ex_q.is_load;

endmodule

// File: tb/tb_rv32i_id_ex_stage.sv
module tb_rv32i_id_ex_stage;
   import rv32i_pkg::*;

`ifdef RV32I_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;
   logic        id_a_pc, id_b_imm, id_reg_write, id_is_load;
   logic        ex_stall, flush;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [31:0] mem_result;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [31:0] wb_result;

   logic        hazard_stall, ex_valid;
   logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [6:0]  ex_funct7;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_is_load;

   rv32i_id_ex_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
      .id_a_pc(id_a_pc), .id_b_imm(id_b_imm),
      .id_reg_write(id_reg_write), .id_is_load(id_is_load),
      .ex_stall(ex_stall), .flush(flush),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the instruction believed to sit in EX.
   logic        m_valid = 1'b0, m_rw = 1'b0, m_ld = 1'b0, m_apc = 1'b0, m_bimm = 1'b0;
   logic [31:0] m_pc = '0, m_d1 = '0, m_d2 = '0, m_imm = '0;
   logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
   logic [6:0]  m_op = '0, m_f7 = '0;
   logic [2:0]  m_f3 = '0;

   logic [6:0] ops [6] = '{OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_AUIPC, OP_JAL};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
      end
   endtask

   // Does decode read a register that some writer will still produce?
   function automatic logic writes_src(input logic en, input logic [4:0] rd);
      return en && rd != 0 && (rd == id_rs1 || rd == id_rs2);
   endfunction

   function automatic logic exp_hazard();
      if (!id_valid) return 1'b0;
      if (FWD) return writes_src(m_valid && m_ld, m_rd);
      return writes_src(m_valid && m_rw, m_rd) || writes_src(mem_reg_write, mem_rd);
   endfunction

   // Value an EX instruction should see for source register rs.
   function automatic logic [31:0] exp_src(input logic [4:0] rs, input logic [31:0] cap);
      if (FWD && rs != 0) begin
         if (mem_reg_write && mem_rd == rs) return mem_result;
         if (wb_reg_write && wb_rd == rs) return wb_result;
      end
      return cap;
   endfunction

   task automatic settle();
      @(negedge clk);
      check("hazard_stall", 32'(hazard_stall), 32'(exp_hazard()));
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      check("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
      if (m_valid) begin
         check("ex_pc", ex_pc, m_pc);
         check("ex_a", ex_a, m_apc ? m_pc : exp_src(m_rs1, m_d1));
         check("ex_b", ex_b, m_bimm ? m_imm : exp_src(m_rs2, m_d2));
         check("ex_store_data", ex_store_data, exp_src(m_rs2, m_d2));
         check("ex_rd", 32'(ex_rd), 32'(m_rd));
         check("ex_opcode", 32'(ex_opcode), 32'(m_op));
         check("ex_funct3", 32'(ex_funct3), 32'(m_f3));
         check("ex_funct7", 32'(ex_funct7), 32'(m_f7));
         check("ex_is_load", 32'(ex_is_load), 32'(m_ld));
      end
   endtask

   task automatic tick();
      logic haz;
      haz = exp_hazard();
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_rw = 0; m_ld = 0; m_apc = 0; m_bimm = 0;
         m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
         m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f7 = 0; m_f3 = 0;
      end else if (flush) begin
         m_valid = 0; m_rw = 0;
      end else if (ex_stall) begin
         if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs1) m_d1 = wb_result;
         if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs2) m_d2 = wb_result;
      end else if (haz) begin
         m_valid = 0; m_rw = 0;
      end else begin
         m_valid = id_valid; m_rw = id_valid && id_reg_write; m_ld = id_is_load;
         m_apc = id_a_pc; m_bimm = id_b_imm; m_pc = id_pc;
         m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
         m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
         m_op = id_opcode; m_f3 = id_funct3; m_f7 = id_funct7;
      end
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [6:0] op, input logic apc,
                         input logic bimm, input logic rw, input logic ld);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_opcode = op;
      id_a_pc = apc; id_b_imm = bimm; id_reg_write = rw; id_is_load = ld;
      id_funct3 = 3'd0; id_funct7 = 7'd0;
   endtask

   task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                          input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
      mem_reg_write = mrw; mem_rd = mrd; mem_result = mres;
      wb_reg_write = wrw; wb_rd = wrd; wb_result = wres;
   endtask

   task automatic random_inputs();
      id_valid     = ($urandom_range(3) != 0);
      id_pc        = $urandom;
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      id_rd        = 5'($urandom_range(3));
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_opcode    = ops[$urandom_range(5)];
      id_funct3    = 3'($urandom);
      id_funct7    = 7'($urandom);
      id_a_pc      = ($urandom_range(3) == 0);
      id_b_imm     = ($urandom_range(1) == 0);
      id_reg_write = ($urandom_range(3) != 0);
      id_is_load   = ($urandom_range(3) == 0);
      ex_stall     = ($urandom_range(7) == 0);
      flush        = ($urandom_range(15) == 0);
      rst          = ($urandom_range(199) == 0);
      set_fwd(($urandom_range(1) == 0), 5'($urandom_range(3)), $urandom,
              ($urandom_range(1) == 0), 5'($urandom_range(3)), $urandom);
   endtask

   initial begin
      rst = 1'b1; ex_stall = 1'b0; flush = 1'b0; id_pc = '0;
      set_id(0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      set_fwd(0, 0, 0, 0, 0, 0);
      tick(); tick();

      // Reset then idle.
      rst = 1'b0;
      settle();
      check("reset_valid", 32'(ex_valid), 32'd0);
      check("reset_reg_write", 32'(ex_reg_write), 32'd0);
      check("reset_hazard", 32'(hazard_stall), 32'd0);
      check("reset_pc", ex_pc, 32'd0);
      tick();

      // ADD x3,x1,x2 then MEM and WB both offer x1: MEM must win.
      set_id(1, 1, 2, 3, 32'd5, 32'd7, 0, OP_REG, 0, 0, 1, 0); id_pc = 32'h100;
      settle(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      set_fwd(1, 1, 32'd100, 1, 1, 32'd200);
      settle();
      check("mem_fwd_a", ex_a, FWD ? 32'd100 : 32'd5);
      check("mem_fwd_b", ex_b, 32'd7);
      tick();

      // x0 is never forwarded.
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 0, 2, 8, 32'd0, 32'd7, 0, OP_REG, 0, 0, 1, 0);
      settle(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      set_fwd(1, 0, 32'hFFFF, 0, 0, 0);
      settle();
      check("x0_guard_a", ex_a, 32'd0);
      tick();

      // Load-use: LW x5 in EX, ADD x6,x5,x1 in decode.
      set_fwd(0, 0, 0, 0, 0, 0);
      set_id(1, 1, 0, 5, 32'h1000, 0, 32'd8, OP_LOAD, 0, 1, 1, 1);
      settle(); tick();
      set_id(1, 5, 1, 6, 32'd0, 32'h22, 0, OP_REG, 0, 0, 1, 0);
      settle();
      check("load_use_stall", 32'(hazard_stall), 32'd1);
      tick();
      settle();
      check("load_use_bubble", 32'(ex_valid), 32'd0);
      check("load_use_release", 32'(hazard_stall), 32'd0);
      tick();
      settle();
      check("load_use_capture_valid", 32'(ex_valid), 32'd1);
      check("load_use_capture_rd", 32'(ex_rd), 32'd6);
      tick();

      // ADDI x4,x2,3 held three cycles; x2 retires through WB in the second.
      set_id(1, 2, 0, 4, 32'h11, 0, 32'd3, OP_IMM, 0, 1, 1, 0);
      settle(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      ex_stall = 1'b1;
      settle(); tick();
      set_fwd(0, 0, 0, 1, 2, 32'h40);
      settle(); tick();
      set_fwd(0, 0, 0, 0, 0, 0);
      settle(); tick();
      ex_stall = 1'b0;
      settle();
      check("refresh_valid", 32'(ex_valid), 32'd1);
      check("refresh_a", ex_a, 32'h40);
      check("refresh_b", ex_b, 32'd3);

      // Flush and stall together: the flush kills the slot.
      flush = 1'b1; ex_stall = 1'b1;
      tick();
      flush = 1'b0; ex_stall = 1'b0;
      settle();
      check("flush_over_stall_valid", 32'(ex_valid), 32'd0);
      check("flush_over_stall_rw", 32'(ex_reg_write), 32'd0);
      tick();

      // SUB x7,x3,x3 while ADD x3 sits in MEM.
      set_id(1, 1, 2, 3, 32'd1, 32'd2, 0, OP_REG, 0, 0, 1, 0);
      settle(); tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 7'd0, 0, 0, 0, 0);
      settle(); tick();
      set_id(1, 3, 3, 7, 32'd0, 32'd0, 0, OP_REG, 0, 0, 1, 0); id_funct7 = 7'h20;
      set_fwd(1, 3, 32'h77, 0, 0, 0);
      settle();
      check("raw_mem_stall", 32'(hazard_stall), FWD ? 32'd0 : 32'd1);
      tick();

      // Randomised traffic with small register indices to force collisions.
      for (int i = 0; i < 600; i++) begin
         random_inputs();
         settle();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
